// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, program ROM and the microcode decoder/execute stage.
// The master modport is the sequencer side; the slave modport is the ROM/decoder side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_req;
  logic              rom_valid;
  logic [7:0]        rom_data;
  logic [7:0]        opcode;
  logic [7:0]        operand;
  logic              instr_valid;
  logic              jump_operation;
  logic              jump_condition;
  logic              exec_done;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    output rom_addr, rom_req, opcode, operand, instr_valid, pc, halted,
    input  rom_valid, rom_data, jump_operation, jump_condition, exec_done, halt
  );

  modport slave (
    input  rom_addr, rom_req, opcode, operand, instr_valid, pc, halted,
    output rom_valid, rom_data, jump_operation, jump_condition, exec_done, halt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: reads 1- or 2-byte instructions from program ROM,
// holds them for the decoder/execute stage and applies taken jumps to the PC.
//
// state       | meaning
// FETCH_OP    | requesting opcode byte at pc
// FETCH_ARG   | requesting operand byte at pc (opcode[7]=1)
// DECODE      | one cycle for the decoder to register its controls
// EXEC        | instruction presented, waiting for exec_done
// HALTED      | stopped until reset
module fetch_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_FETCH_ARG,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              rom_req_q;
  logic [7:0]        opcode_q;
  logic [7:0]        operand_q;
  logic              instr_valid_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc_inc_d;
  logic [ADDR_W-1:0] jump_pc_d;

  assign pc_inc_d  = pc_q + ADDR_W'(1);
  assign jump_pc_d = ADDR_W'(operand_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH_OP;
      pc_q          <= ADDR_W'(RESET_PC);
      rom_req_q     <= 1'b0;
      opcode_q      <= 8'h00;
      operand_q     <= 8'h00;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH_OP: begin
          // First cycle after reset raises the request; afterwards EXEC raises it on exit.
          if (!rom_req_q) begin
            rom_req_q <= 1'b1;
          end else if (bus.rom_valid) begin
            opcode_q <= bus.rom_data;
            pc_q     <= pc_inc_d;
            if (bus.rom_data[7]) begin
              state_q <= S_FETCH_ARG;
            end else begin
              operand_q <= 8'h00;
              rom_req_q <= 1'b0;
              state_q   <= S_DECODE;
            end
          end
        end
        S_FETCH_ARG: begin
          if (bus.rom_valid) begin
            operand_q <= bus.rom_data;
            pc_q      <= pc_inc_d;
            rom_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          instr_valid_q <= 1'b1;
          state_q       <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            instr_valid_q <= 1'b0;
            if (bus.jump_operation && bus.jump_condition) begin
              pc_q <= jump_pc_d;
            end
            if (bus.halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end else begin
              rom_req_q <= 1'b1;
              state_q   <= S_FETCH_OP;
            end
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q       <= S_HALTED;
          halted_q      <= 1'b1;
          rom_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.rom_req     = rom_req_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;

endmodule
